product_bcd_display: RTL and testbench

- Downstream display stage for the 5x5 switch multiplier.
- Consumes the 10-bit product (0..1023; the 5x5 maximum is 961) and converts it to four BCD digits with a sequential double-dabble engine, one bit per clock.
- Drives four active-low 7-segment displays (HEX3..HEX0) from registered digits.
- Uses a VALID/BUSY/DONE handshake so the displays update atomically, never mid-conversion.

---
 rtl/product_bcd_display.sv | 98 +++++++++
 tb/tb_product_bcd_display.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/product_bcd_display.sv
// product_bcd_display: converts a 10-bit product to four BCD digits (one bit per clock) and drives four 7-segment displays
//   CLOCK_50        system clock, rising edge
//   RST_N           asynchronous active-low reset
//   PRODUCT[9:0]    unsigned value to display, captured when VALID is accepted
//   VALID           conversion request, sampled only while idle
//   BUSY            high while a conversion is in progress
//   DONE            one-cycle pulse after the HEX outputs have been updated
//   HEX3..HEX0      active-low segments {g,f,e,d,c,b,a}: thousands..ones
module product_bcd_display #(
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic       CLOCK_50,
    input  logic       RST_N,
    input  logic [9:0] PRODUCT,
    input  logic       VALID,
    output logic       BUSY,
    output logic       DONE,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3
);
    typedef enum logic [1:0] {IDLE, CONV, UPD} state_t;

    localparam logic [6:0] BLANK  = 7'h7F;
    localparam logic [6:0] ZERO   = 7'h40;
    localparam logic [6:0] LZ_RST = BLANK_LZ ? BLANK : ZERO;

    state_t      state, state_nx;
    logic [3:0]  cnt;
    logic [25:0] sr, sr_adj;
    logic [3:0]  d3, d2, d1, d0;
    logic        bl3, bl2, bl1;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return n >= 4'd5 ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return BLANK;
        endcase
    endfunction

    assign {d3, d2, d1, d0} = sr[25:10];
    // blanking cascades from the most significant digit downwards; HEX0 is never blanked
    assign bl3  = BLANK_LZ && d3 == 4'd0;
    assign bl2  = bl3 && d2 == 4'd0;
    assign bl1  = bl2 && d1 == 4'd0;
    assign BUSY = state != IDLE;

    always_comb begin
        sr_adj   = {add3(d3), add3(d2), add3(d1), add3(d0), sr[9:0]};
        state_nx = state == IDLE ? (VALID ? CONV : IDLE)
                 : state == CONV ? (cnt == 4'd9 ? UPD : CONV)
                 : IDLE;
    end

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            cnt   <= '0;
            sr    <= '0;
            DONE  <= 1'b0;
            HEX0  <= ZERO;
            HEX1  <= LZ_RST;
            HEX2  <= LZ_RST;
            HEX3  <= LZ_RST;
        end else begin
            state <= state_nx;
            DONE  <= state == UPD;
            if (state == IDLE && VALID) begin
                sr  <= {16'd0, PRODUCT};
                cnt <= '0;
            end
            if (state == CONV) begin
                sr  <= {sr_adj[24:0], 1'b0};
                cnt <= cnt + 4'd1;
            end
            if (state == UPD) begin
                HEX3 <= bl3 ? BLANK : seg(d3);
                HEX2 <= bl2 ? BLANK : seg(d2);
                HEX1 <= bl1 ? BLANK : seg(d1);
                HEX0 <= seg(d0);
            end
        end
    end
endmodule

// File: tb/tb_product_bcd_display.sv
// tb_product_bcd_display: scoreboard bench for product_bcd_display, blanking on (a) and off (b) side by side
module tb_product_bcd_display;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] product = '0;
    logic       valid = 1'b0;
    logic       busy_a, done_a, busy_b, done_b;
    logic [6:0] h0a, h1a, h2a, h3a, h0b, h1b, h2b, h3b;
    int         total = 0;
    int         bad = 0;
    logic [27:0] q_a[$];
    logic [27:0] q_b[$];
    logic [6:0]  seg_tab[10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    always #10 clk = ~clk;

    product_bcd_display #(.BLANK_LZ(1'b1)) dut_a (
        .CLOCK_50(clk), .RST_N(rst_n), .PRODUCT(product), .VALID(valid),
        .BUSY(busy_a), .DONE(done_a), .HEX0(h0a), .HEX1(h1a), .HEX2(h2a), .HEX3(h3a)
    );
    product_bcd_display #(.BLANK_LZ(1'b0)) dut_b (
        .CLOCK_50(clk), .RST_N(rst_n), .PRODUCT(product), .VALID(valid),
        .BUSY(busy_b), .DONE(done_b), .HEX0(h0b), .HEX1(h1b), .HEX2(h2b), .HEX3(h3b)
    );

    task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // expected {HEX3,HEX2,HEX1,HEX0} from decimal digits of the value
    function automatic logic [27:0] model(input int p, input bit blz);
        int d3, d2, d1, d0;
        logic [6:0] h3, h2, h1;
        d3 = p / 1000;
        d2 = (p / 100) % 10;
        d1 = (p / 10) % 10;
        d0 = p % 10;
        h3 = (blz && d3 == 0) ? 7'h7F : seg_tab[d3];
        h2 = (blz && d3 == 0 && d2 == 0) ? 7'h7F : seg_tab[d2];
        h1 = (blz && d3 == 0 && d2 == 0 && d1 == 0) ? 7'h7F : seg_tab[d1];
        return {h3, h2, h1, seg_tab[d0]};
    endfunction

    // monitor: every DONE pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && done_a) begin
            if (q_a.size() == 0) check("unexpected_done_a", 28'd1, 28'd0);
            else check("hex_a", {h3a, h2a, h1a, h0a}, q_a.pop_front());
        end
        if (rst_n && done_b) begin
            if (q_b.size() == 0) check("unexpected_done_b", 28'd1, 28'd0);
            else check("hex_b", {h3b, h2b, h1b, h0b}, q_b.pop_front());
        end
    end

    task automatic push(input int p);
        q_a.push_back(model(p, 1'b1));
        q_b.push_back(model(p, 1'b0));
    endtask

    // issue one request, then scramble PRODUCT and wait (bounded) for idle
    task automatic convert(input int p);
        int n;
        @(negedge clk);
        product = 10'(p);
        valid = 1'b1;
        push(p);
        @(posedge clk);
        #1 valid = 1'b0;
        product = 10'($urandom);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy_a && n < 20);
        check("idle_timeout", 28'(busy_a), 28'd0);
    endtask

    // request with cycle-exact BUSY/DONE checks
    task automatic convert_timed(input int p);
        @(negedge clk);
        product = 10'(p);
        valid = 1'b1;
        push(p);
        @(posedge clk);
        #1 valid = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            check($sformatf("busy_k+%0d", i), {26'd0, busy_a, done_a}, 28'b10);
        end
        @(posedge clk);
        #1 check("done_k+11", {26'd0, busy_a, done_a}, 28'b01);
        @(posedge clk);
        #1 check("done_k+12", {26'd0, busy_a, done_a}, 28'b00);
    endtask

    initial begin
        int dt[$];
        #35;
        check("rst_a", {busy_a, done_a, h3a, h2a, h1a, h0a}, {2'b00, 7'h7F, 7'h7F, 7'h7F, 7'h40});
        check("rst_b", {busy_b, done_b, h3b, h2b, h1b, h0b}, {2'b00, 7'h40, 7'h40, 7'h40, 7'h40});
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_hold_a", {busy_a, done_a, h3a, h2a, h1a, h0a}, {2'b00, 7'h7F, 7'h7F, 7'h7F, 7'h40});
        convert_timed(961);
        convert(1023);
        convert(5);
        convert(0);
        convert(100);
        convert(42);
        // VALID and PRODUCT activity mid-conversion must be ignored
        @(negedge clk);
        product = 10'd961;
        valid = 1'b1;
        push(961);
        @(posedge clk);
        #1 valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 product = 10'd25;
        valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        repeat (25) @(negedge clk);
        // held VALID: one conversion every 12 cycles
        @(negedge clk);
        product = 10'd777;
        valid = 1'b1;
        push(777);
        push(777);
        push(777);
        for (int c = 0; c <= 36; c++) begin
            @(posedge clk);
            #1;
            if (c == 24) valid = 1'b0;
            if (done_a) dt.push_back(c);
        end
        check("held_count", 28'(dt.size()), 28'd3);
        if (dt.size() == 3) begin
            check("held_first", 28'(dt[0]), 28'd11);
            check("held_period1", 28'(dt[1] - dt[0]), 28'd12);
            check("held_period2", 28'(dt[2] - dt[1]), 28'd12);
        end
        // reset in mid-conversion aborts without DONE
        @(negedge clk);
        product = 10'd961;
        valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        repeat (6) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_a", {busy_a, done_a, h3a, h2a, h1a, h0a}, {2'b00, 7'h7F, 7'h7F, 7'h7F, 7'h40});
        check("abort_b", {busy_b, done_b, h3b, h2b, h1b, h0b}, {2'b00, 7'h40, 7'h40, 7'h40, 7'h40});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("abort_quiet", {26'd0, busy_a, done_a}, 28'd0);
        convert(42);
        for (int i = 0; i < 30; i++) begin
            convert(int'($urandom_range(0, 1023)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        convert(999);
        convert(1000);
        repeat (4) @(negedge clk);
        check("queue_a_empty", 28'(q_a.size()), 28'd0);
        check("queue_b_empty", 28'(q_b.size()), 28'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
